// File: rtl/cache_dre_maint_pkg.sv
// Shared state encodings and DRE byte-mask constants for the DRE maintenance sequencer.
package cache_dre_pkg;

  typedef enum logic [2:0] {
    ST_INIT  = 3'd0,
    ST_IDLE  = 3'd1,
    ST_CLEAR = 3'd2,
    ST_FILL  = 3'd3,
    ST_DONE  = 3'd4
  } dre_state_e;

  localparam logic [7:0] DRE_NONE = 8'h00;
  localparam logic [7:0] DRE_ALL  = 8'hFF;

endpackage

// File: rtl/cache_dre_maint_if.sv
// Request/ack handshake plus DRE store write port of the maintenance sequencer.
interface cache_dre_maint_if #(
  parameter int ADDR_WIDTH     = 8,
  parameter int LINE_ROWS_LOG2 = 2
);
  logic                                   clr_req;
  logic                                   clr_ack;
  logic                                   fill_req;
  logic [1:0]                             fill_ch;
  logic [ADDR_WIDTH-2-LINE_ROWS_LOG2:0]   fill_line;
  logic                                   fill_ack;
  logic                                   busy;
  logic                                   sel;
  logic [ADDR_WIDTH-1:0]                  ri_writeAddress;
  logic [1:0]                             ri_writeChannel;
  logic                                   ri_writeEnable;
  logic [7:0]                             ri_writeData;

  modport mst (
    output clr_req, fill_req, fill_ch, fill_line,
    input  clr_ack, fill_ack, busy, sel,
    input  ri_writeAddress, ri_writeChannel, ri_writeEnable, ri_writeData
  );

  modport slv (
    input  clr_req, fill_req, fill_ch, fill_line,
    output clr_ack, fill_ack, busy, sel,
    output ri_writeAddress, ri_writeChannel, ri_writeEnable, ri_writeData
  );
endinterface

// File: rtl/cache_dre_maint_sweep_cnt.sv
// Loadable sweep counter; terminal count covers either the full store or one cache line.
module cache_dre_sweep_cnt #(
  parameter int ADDR_WIDTH     = 8,
  parameter int LINE_ROWS_LOG2 = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic                i_inc,
  input  logic                i_line_range,
  output logic [ADDR_WIDTH:0] o_cnt,
  output logic                o_tc
);

  localparam logic [ADDR_WIDTH:0]       CNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
  localparam logic [ADDR_WIDTH:0]       CNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH:0]       CNT_MAX  = {(ADDR_WIDTH+1){1'b1}};
  localparam logic [LINE_ROWS_LOG2-1:0] LINE_MAX = {LINE_ROWS_LOG2{1'b1}};

  logic [ADDR_WIDTH:0] r_cnt;

  // counter register: load to zero outside a sweep, advance once per write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= CNT_ZERO;
    end else if (i_load) begin
      r_cnt <= CNT_ZERO;
    end else if (i_inc) begin
      r_cnt <= r_cnt + CNT_ONE;
    end else begin
      r_cnt <= r_cnt;
    end
  end

  // line mode only looks at the in-line bits because a fill always starts from zero
  always_comb begin
    o_tc = 1'b0;
    if (i_line_range) begin
      o_tc = (r_cnt[LINE_ROWS_LOG2-1:0] == LINE_MAX);
    end else begin
      o_tc = (r_cnt == CNT_MAX);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/cache_dre_maint.sv
// DRE store maintenance sequencer: full clear and per-line fill.
// Optional build macro CACHE_DRE_MAINT_AUTOCLR_EN: full clear after every reset release.
module cache_dre_maint
  import cache_dre_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int LINE_ROWS_LOG2 = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_dre_maint_if.slv   bus
);

  localparam int LINE_W = ADDR_WIDTH - 1 - LINE_ROWS_LOG2;

  dre_state_e               r_state;
  logic [1:0]               r_fill_ch;
  logic [LINE_W-1:0]        r_fill_line;
  logic                     r_is_fill;
  logic                     r_auto;
  logic [ADDR_WIDTH:0]      w_cnt;
  logic                     w_tc;
  logic                     w_active;
  logic [ADDR_WIDTH-2:0]    w_row;

  assign w_active = (r_state == ST_CLEAR) || (r_state == ST_FILL);

  cache_dre_sweep_cnt #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .LINE_ROWS_LOG2 (LINE_ROWS_LOG2)
  ) u_cnt (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load       (!w_active),
    .i_inc        (w_active),
    .i_line_range (r_state == ST_FILL),
    .o_cnt        (w_cnt),
    .o_tc         (w_tc)
  );

  // sequencer FSM; r_auto marks the post-reset sweep so it completes without an ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_INIT;
      r_fill_ch   <= 2'd0;
      r_fill_line <= {LINE_W{1'b0}};
      r_is_fill   <= 1'b0;
      r_auto      <= 1'b0;
    end else begin
      case (r_state)
        ST_INIT: begin
`ifdef CACHE_DRE_MAINT_AUTOCLR_EN
          r_state   <= ST_CLEAR;
          r_auto    <= 1'b1;
`else
          r_state   <= ST_IDLE;
          r_auto    <= 1'b0;
`endif
          r_is_fill <= 1'b0;
        end
        ST_IDLE: begin
          if (bus.clr_req) begin
            r_state   <= ST_CLEAR;
            r_is_fill <= 1'b0;
            r_auto    <= 1'b0;
          end else if (bus.fill_req) begin
            r_state     <= ST_FILL;
            r_is_fill   <= 1'b1;
            r_auto      <= 1'b0;
            r_fill_ch   <= bus.fill_ch;
            r_fill_line <= bus.fill_line;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_CLEAR, ST_FILL: begin
          if (w_tc) begin
            r_state <= ST_DONE;
          end else begin
            r_state <= r_state;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // output decode from registered state, counter and latched fill target only
  always_comb begin
    w_row                = {(ADDR_WIDTH-1){1'b0}};
    bus.ri_writeChannel  = 2'd0;
    bus.ri_writeData     = DRE_NONE;
    case (r_state)
      ST_CLEAR: begin
        w_row               = w_cnt[ADDR_WIDTH:2];
        bus.ri_writeChannel = w_cnt[1:0];
        bus.ri_writeData    = DRE_NONE;
      end
      ST_FILL: begin
        w_row               = {r_fill_line, w_cnt[LINE_ROWS_LOG2-1:0]};
        bus.ri_writeChannel = r_fill_ch;
        bus.ri_writeData    = DRE_ALL;
      end
      default: begin
        w_row               = {(ADDR_WIDTH-1){1'b0}};
        bus.ri_writeChannel = 2'd0;
        bus.ri_writeData    = DRE_NONE;
      end
    endcase
  end

  assign bus.ri_writeAddress = {w_row, 1'b0};
  assign bus.ri_writeEnable  = w_active;
  assign bus.busy            = w_active;
  assign bus.sel             = w_active;
  assign bus.clr_ack         = (r_state == ST_DONE) && !r_is_fill && !r_auto;
  assign bus.fill_ack        = (r_state == ST_DONE) && r_is_fill;

endmodule

// File: tb/tb_cache_dre_maint.sv
// Directed bench for cache_dre_maint: table of fill vectors plus clear/priority/reset sequences.
module tb_cache_dre_maint;
  localparam int AW  = 8;
  localparam int LRL = 2;
  localparam int LW  = AW - 1 - LRL;

  typedef logic [22:0] obs_t;
  typedef struct {
    logic [1:0]    ch;
    logic [LW-1:0] line;
    logic [7:0]    base;
  } fill_vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  fill_vec_t vecs[4];

  cache_dre_maint_if #(.ADDR_WIDTH(AW), .LINE_ROWS_LOG2(LRL)) bus();

  cache_dre_maint #(.ADDR_WIDTH(AW), .LINE_ROWS_LOG2(LRL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic obs_t pack_exp(logic busy, logic [7:0] data, logic [1:0] ch,
                                    logic [7:0] addr, logic cack, logic fack);
    return {busy, busy, busy, data, ch, addr, cack, fack};
  endfunction

  function automatic obs_t obs();
    return {bus.busy, bus.sel, bus.ri_writeEnable, bus.ri_writeData, bus.ri_writeChannel,
            bus.ri_writeAddress, bus.clr_ack, bus.fill_ack};
  endfunction

  task automatic check(input string name, input obs_t exp);
    obs_t act;
    act = obs();
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (busy,sel,we,data,ch,addr,cack,fack)", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    check(name, pack_exp(1'b0, 8'h00, 2'd0, 8'd0, 1'b0, 1'b0));
  endtask

  // entered on the cycle of write 0; returns on the ack cycle
  task automatic expect_clear(input logic exp_ack);
    for (int k = 0; k < 512; k++) begin
      logic [8:0] kv;
      kv = k[8:0];
      check($sformatf("clear_w%0d", k), pack_exp(1'b1, 8'h00, kv[1:0], {kv[8:2], 1'b0}, 1'b0, 1'b0));
      step();
    end
    check("clear_ack", pack_exp(1'b0, 8'h00, 2'd0, 8'd0, exp_ack, 1'b0));
  endtask

  task automatic expect_fill(input logic [7:0] base, input logic [1:0] ch, input logic scramble);
    for (int k = 0; k < 4; k++) begin
      logic [7:0] a;
      a = base + 8'(2 * k);
      check($sformatf("fill_w%0d", k), pack_exp(1'b1, 8'hFF, ch, a, 1'b0, 1'b0));
      if (scramble && k == 0) begin
        bus.fill_ch   = bus.fill_ch ^ 2'b11;
        bus.fill_line = bus.fill_line ^ {LW{1'b1}};
      end
      step();
    end
    check("fill_ack", pack_exp(1'b0, 8'h00, 2'd0, 8'd0, 1'b0, 1'b1));
  endtask

  initial begin
    vecs[0] = '{ch: 2'd2, line: 5'd1,  base: 8'd8};
    vecs[1] = '{ch: 2'd0, line: 5'd0,  base: 8'd0};
    vecs[2] = '{ch: 2'd3, line: 5'd31, base: 8'd248};
    vecs[3] = '{ch: 2'd1, line: 5'd17, base: 8'd136};

    rst_n         = 1'b1;
    bus.clr_req   = 1'b0;
    bus.fill_req  = 1'b0;
    bus.fill_ch   = 2'd0;
    bus.fill_line = 5'd0;
    #2 rst_n = 1'b0;
    #1 check_idle("reset_state");
    repeat (2) @(posedge clk);
    #1 check_idle("reset_held");
    rst_n = 1'b1;
    step();
`ifdef CACHE_DRE_MAINT_AUTOCLR_EN
    expect_clear(1'b0);
    step();
    check_idle("auto_done_idle");
`else
    check_idle("post_reset_idle");
`endif
    step();
    check_idle("idle_settled");

    // table-driven fills, target inputs scrambled after the first write
    for (int i = 0; i < 4; i++) begin
      bus.fill_ch   = vecs[i].ch;
      bus.fill_line = vecs[i].line;
      bus.fill_req  = 1'b1;
      step();
      expect_fill(vecs[i].base, vecs[i].ch, 1'b1);
      bus.fill_req = 1'b0;
      step();
      check_idle("fill_gap");
      step();
      check_idle("fill_single");
    end

    // clear wins over a simultaneous fill; fill follows after one idle cycle
    bus.clr_req   = 1'b1;
    bus.fill_req  = 1'b1;
    bus.fill_ch   = 2'd2;
    bus.fill_line = 5'd1;
    step();
    expect_clear(1'b1);
    bus.clr_req = 1'b0;
    step();
    check_idle("prio_gap");
    step();
    expect_fill(8'd8, 2'd2, 1'b0);
    bus.fill_req = 1'b0;
    step();
    check_idle("prio_after");
    step();

    // request held past the ack starts a second fill
    bus.fill_ch   = 2'd1;
    bus.fill_line = 5'd3;
    bus.fill_req  = 1'b1;
    step();
    expect_fill(8'd24, 2'd1, 1'b0);
    step();
    check_idle("held_gap");
    step();
    expect_fill(8'd24, 2'd1, 1'b0);
    bus.fill_req = 1'b0;
    step();
    check_idle("held_after");
    step();
    check_idle("held_single");

    // reset at write 100 of a clear
    bus.clr_req = 1'b1;
    step();
    repeat (100) step();
    check("clear_w100_pre", pack_exp(1'b1, 8'h00, 2'd0, 8'd50, 1'b0, 1'b0));
    rst_n       = 1'b0;
    bus.clr_req = 1'b0;
    #1 check_idle("reset_mid_clear");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
`ifdef CACHE_DRE_MAINT_AUTOCLR_EN
    expect_clear(1'b0);
    step();
    check_idle("restart_done");
`else
    check_idle("restart_idle");
    step();
    check_idle("restart_idle2");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
